mux_scan_sel: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with active-high enable and an auto-scan mode. It is the next generation of the team's enable-gated 4:1 selector. Outputs are forced to all-ones while disabled, matching the existing selector's idle level. It sits between grouped input sources (switch banks, sensor lines) and single-channel consumers such as display or UART paths. Channels are chosen either directly by `sel` or by a dwell-timed round-robin scanner.

---
 rtl/mux_scan_sel.sv | 88 ++++++++
 tb/tb_mux_scan_sel.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: N-channel, W-bit registered mux with enable gating and dwell-timed auto-scan.
// Define MUX_SCAN_MASK_EN to add the per-channel mask input.
module mux_scan_sel #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int DWELL = 4,
    parameter int SW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] din,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N-1:0]   mask,
`endif
    output logic [W-1:0]   y,
    output logic [SW-1:0]  ch,
    output logic           ch_stb
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] ch_n, ch_nxt, idx;
    logic [W-1:0]  y_n, ch_data;
    logic [N-1:0]  elig;
    logic          pass;

`ifdef MUX_SCAN_MASK_EN
    assign elig = mask;
`else
    assign elig = '1;
`endif

    // Nearest eligible channel after ch; lands on ch itself when it is the only one.
    always_comb begin
        ch_nxt = ch;
        idx    = '0;
        for (int k = N; k >= 1; k--) begin
            idx = SW'((int'(ch) + k) % N);
            if (elig[idx]) ch_nxt = idx;
        end
    end

    // Counter clears whenever not scanning, so any mode change restarts a full dwell.
    always_comb begin
        ch_n  = ch;
        cnt_n = '0;
        pass  = 1'b0;
        if (en) begin
            if (!mode) begin
                if (int'(sel) < N) begin
                    ch_n = sel;
                    pass = 1'b1;
                end
            end else begin
                pass = 1'b1;
                if (cnt == CNT_LAST) ch_n = ch_nxt;
                else cnt_n = cnt + CW'(1);
            end
        end
    end

    always_comb begin
        ch_data = '1;
        for (int j = 0; j < N; j++) begin
            if (ch_n == SW'(j)) ch_data = din[j*W +: W];
        end
        y_n = (pass && elig[ch_n]) ? ch_data : '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y      <= '1;
            ch     <= '0;
            ch_stb <= 1'b0;
            cnt    <= '0;
        end else begin
            y      <= y_n;
            ch     <= ch_n;
            ch_stb <= (ch_n != ch);
            cnt    <= cnt_n;
        end
    end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel: N=4/DWELL=4 and N=3/DWELL=1 instances, vector table plus scan sequences.
// Mask scenarios are compiled in when MUX_SCAN_MASK_EN is defined.
module tb_mux_scan_sel;
    localparam logic [31:0] D4 = 32'h44332211;
    localparam logic [31:0] DL = 32'hA5332211;
    localparam logic [23:0] D3 = 24'hCCBBAA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, en4, mode4;
    logic [1:0]  sel4;
    logic [31:0] din4;
    logic [7:0]  y4;
    logic [1:0]  ch4;
    logic        stb4;

    logic        rst3, en3, mode3;
    logic [1:0]  sel3;
    logic [23:0] din3;
    logic [7:0]  y3;
    logic [1:0]  ch3;
    logic        stb3;

`ifdef MUX_SCAN_MASK_EN
    logic [3:0] mask4;
    logic [2:0] mask3;
`endif

    mux_scan_sel #(.N(4), .W(8), .DWELL(4)) dut (
        .clk    (clk),
        .rst    (rst4),
        .en     (en4),
        .mode   (mode4),
        .sel    (sel4),
        .din    (din4),
`ifdef MUX_SCAN_MASK_EN
        .mask   (mask4),
`endif
        .y      (y4),
        .ch     (ch4),
        .ch_stb (stb4)
    );

    mux_scan_sel #(.N(3), .W(8), .DWELL(1)) dut3 (
        .clk    (clk),
        .rst    (rst3),
        .en     (en3),
        .mode   (mode3),
        .sel    (sel3),
        .din    (din3),
`ifdef MUX_SCAN_MASK_EN
        .mask   (mask3),
`endif
        .y      (y3),
        .ch     (ch3),
        .ch_stb (stb3)
    );

    typedef struct {
        logic [7:0] y;
        logic [1:0] ch;
        logic       stb;
        string      name;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        en;
        logic        mode;
        logic [1:0]  sel;
        logic [31:0] din;
        logic [7:0]  y;
        logic [1:0]  ch;
        logic        stb;
    } vec_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic logic [7:0] byte4(input int c);
        return 8'(D4 >> (8 * c));
    endfunction

    function automatic logic [7:0] byte3(input int c);
        return 8'(D3 >> (8 * c));
    endfunction

    task automatic push(input logic [7:0] ey, input logic [1:0] ech, input logic estb,
                        input string nm);
        exp_t e;
        e.y = ey;
        e.ch = ech;
        e.stb = estb;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic check(input logic [7:0] gy, input logic [1:0] gch, input logic gstb);
        exp_t e;
        if (sb.size() == 0) begin
            nerr++;
            $display("FAIL scoreboard_empty: got y=%h ch=%0d stb=%b, nothing expected",
                     gy, gch, gstb);
            return;
        end
        e = sb.pop_front();
        nvec++;
        if (gy !== e.y || gch !== e.ch || gstb !== e.stb) begin
            nerr++;
            $display("FAIL %s: got y=%h ch=%0d stb=%b, expected y=%h ch=%0d stb=%b",
                     e.name, gy, gch, gstb, e.y, e.ch, e.stb);
        end
    endtask

    task automatic step4(input logic r, input logic e, input logic m, input logic [1:0] s,
                         input logic [31:0] d, input logic [7:0] ey, input logic [1:0] ech,
                         input logic estb, input string nm);
        rst4 = r; en4 = e; mode4 = m; sel4 = s; din4 = d;
        push(ey, ech, estb, nm);
        @(posedge clk);
        #1;
        check(y4, ch4, stb4);
    endtask

    task automatic step3(input logic r, input logic e, input logic m, input logic [1:0] s,
                         input logic [7:0] ey, input logic [1:0] ech, input logic estb,
                         input string nm);
        rst3 = r; en3 = e; mode3 = m; sel3 = s; din3 = D3;
        push(ey, ech, estb, nm);
        @(posedge clk);
        #1;
        check(y3, ch3, stb3);
    endtask

    // Scan from channel start with the dwell counter at 0; sel is ignored in scan mode.
    task automatic scan4(input int start, input int cycles, input string nm);
        int c;
        for (int k = 0; k < cycles; k++) begin
            c = (start + (k + 1) / 4) % 4;
            step4(1'b0, 1'b1, 1'b1, 2'(k), D4, byte4(c), 2'(c), ((k + 1) % 4) == 0, nm);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[14];
        int   c;

        rst4 = 1'b1; en4 = 1'b0; mode4 = 1'b0; sel4 = '0; din4 = D4;
        rst3 = 1'b1; en3 = 1'b0; mode3 = 1'b0; sel3 = '0; din3 = D3;
`ifdef MUX_SCAN_MASK_EN
        mask4 = 4'hF;
        mask3 = 3'h7;
`endif

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, D4, 8'hFF, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd2, D4, 8'h33, 2'd2, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd2, D4, 8'h33, 2'd2, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd2, D4, 8'hFF, 2'd2, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'd2, D4, 8'hFF, 2'd2, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd2, D4, 8'hFF, 2'd2, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'd2, D4, 8'h33, 2'd2, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, D4, 8'h11, 2'd0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'd3, D4, 8'h44, 2'd3, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd3, DL, 8'hA5, 2'd3, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 2'd1, D4, 8'h22, 2'd1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 2'd1, D4, 8'hFF, 2'd1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 2'd3, D4, 8'hFF, 2'd1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 2'd0, D4, 8'h11, 2'd0, 1'b1};

        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) begin
            step4(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].sel, tbl[i].din,
                  tbl[i].y, tbl[i].ch, tbl[i].stb, $sformatf("vec%0d", i));
        end

        // Full rotation and beyond, ending mid-dwell on channel 3
        scan4(0, 29, "scan");
        step4(1'b1, 1'b1, 1'b1, 2'd0, D4, 8'hFF, 2'd0, 1'b0, "rst_mid_dwell");
        scan4(0, 9, "scan_after_rst");
        step4(1'b0, 1'b1, 1'b0, 2'd2, D4, 8'h33, 2'd2, 1'b0, "mode_switch");
        scan4(2, 6, "scan_resume");

`ifdef MUX_SCAN_MASK_EN
        mask4 = 4'b1010;
        step4(1'b0, 1'b1, 1'b0, 2'd1, D4, 8'h22, 2'd1, 1'b1, "mask_prep");
        for (int k = 0; k < 12; k++) begin
            c = (((k + 1) / 4) % 2 == 1) ? 3 : 1;
            step4(1'b0, 1'b1, 1'b1, 2'd0, D4, byte4(c), 2'(c), ((k + 1) % 4) == 0,
                  "mask_scan");
        end
        mask4 = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            step4(1'b0, 1'b1, 1'b1, 2'd0, D4, 8'hFF, 2'd3, 1'b0, "mask_none");
        end
        mask4 = 4'b1010;
        step4(1'b0, 1'b1, 1'b0, 2'd0, D4, 8'hFF, 2'd0, 1'b1, "sel_masked");
        mask4 = 4'hF;
`endif

        rst4 = 1'b1;
        step3(1'b1, 1'b0, 1'b0, 2'd0, 8'hFF, 2'd0, 1'b0, "n3_reset");
        step3(1'b0, 1'b1, 1'b0, 2'd2, byte3(2), 2'd2, 1'b1, "n3_sel2");
        step3(1'b0, 1'b1, 1'b0, 2'd3, 8'hFF, 2'd2, 1'b0, "n3_sel_oob");
        step3(1'b0, 1'b1, 1'b0, 2'd0, byte3(0), 2'd0, 1'b1, "n3_sel0");
        for (int k = 0; k < 5; k++) begin
            c = (k + 1) % 3;
            step3(1'b0, 1'b1, 1'b1, 2'd0, byte3(c), 2'(c), 1'b1, "n3_dwell1");
        end
        step3(1'b0, 1'b0, 1'b1, 2'd0, 8'hFF, 2'd2, 1'b0, "n3_disable");

        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_leftover: got %0d pending, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
